// File: rtl/json_scan_ctrl.sv
// json_scan_ctrl: streaming structural scanner for the JSON decoding datapath.
// Walks a byte stream, tracks string/escape/scalar lexical state and a
// bracket nesting stack, emits one structural token per significant byte and
// reports the first syntax error with its kind and byte position.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input byte handshake
//   in_data[7:0], in_last    input byte, final byte of the document
//   tok_valid/tok_ready      token handshake (held until accepted)
//   tok_kind[3:0]            1 OBJ_START 2 OBJ_END 3 ARR_START 4 ARR_END
//                            5 STR_START 6 STR_END 7 SCALAR_START 8 COLON 9 COMMA
//   tok_pos[POS_W-1:0]       byte index of the token character
//   tok_depth[DW-1:0]        nesting depth after the token is applied
//   done                     sticky, document complete without error
//   err, err_kind[2:0]       sticky error flag and kind
//                            1 EOF_VALUE 2 EOF_STRING 3 BRACKET_MISMATCH
//                            4 DEPTH_OVERFLOW 5 TRAILING_CHARS 6 UNEXPECTED_CHAR
//   err_pos[POS_W-1:0]       byte index of the offending byte
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_EXPECT     | a value (or a close of an empty container) must come next
// S_IN_STR     | inside a string body
// S_IN_ESC     | byte after a backslash inside a string
// S_IN_SCALAR  | inside a number/literal, ends at whitespace or structural char
// S_AFTER      | a value completed inside a container; ',' ':' or close next
// S_TOP_DONE   | top-level value complete; only whitespace is legal

module json_scan_ctrl #(
  parameter int MAX_DEPTH = 16,
  parameter int POS_W     = 32,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [3:0]       tok_kind,
  output logic [POS_W-1:0] tok_pos,
  output logic [DW-1:0]    tok_depth,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_kind,
  output logic [POS_W-1:0] err_pos
);

  localparam logic [2:0] S_EXPECT    = 3'd0;
  localparam logic [2:0] S_IN_STR    = 3'd1;
  localparam logic [2:0] S_IN_ESC    = 3'd2;
  localparam logic [2:0] S_IN_SCALAR = 3'd3;
  localparam logic [2:0] S_AFTER     = 3'd4;
  localparam logic [2:0] S_TOP_DONE  = 3'd5;

  localparam logic [3:0] K_OBJ_START = 4'd1;
  localparam logic [3:0] K_OBJ_END   = 4'd2;
  localparam logic [3:0] K_ARR_START = 4'd3;
  localparam logic [3:0] K_ARR_END   = 4'd4;
  localparam logic [3:0] K_STR_START = 4'd5;
  localparam logic [3:0] K_STR_END   = 4'd6;
  localparam logic [3:0] K_SCALAR    = 4'd7;
  localparam logic [3:0] K_COLON     = 4'd8;
  localparam logic [3:0] K_COMMA     = 4'd9;

  localparam logic [2:0] E_EOF_VALUE  = 3'd1;
  localparam logic [2:0] E_EOF_STRING = 3'd2;
  localparam logic [2:0] E_MISMATCH   = 3'd3;
  localparam logic [2:0] E_OVERFLOW   = 3'd4;
  localparam logic [2:0] E_TRAILING   = 3'd5;
  localparam logic [2:0] E_UNEXPECTED = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;   // bit i: 1 = object at depth i+1
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 just_opened_q, just_opened_d;
  logic                 tok_valid_q, tok_valid_d;
  logic [3:0]           tok_kind_q, tok_kind_d;
  logic [POS_W-1:0]     tok_pos_q, tok_pos_d;
  logic [DW-1:0]        tok_depth_q, tok_depth_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [2:0]           err_kind_q, err_kind_d;
  logic [POS_W-1:0]     err_pos_q, err_pos_d;

  logic is_ws, is_lbrace, is_rbrace, is_lbrack, is_rbrack;
  logic is_open, is_close, is_quote, is_bslash, is_colon, is_comma;
  logic is_struct, is_scalar_start, top_is_obj;
  logic accept;

  assign in_ready = !done_q && !err_q && (!tok_valid_q || tok_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    is_ws      = (in_data == 8'h20) || (in_data == 8'h09) ||
                 (in_data == 8'h0A) || (in_data == 8'h0D);
    is_lbrace  = (in_data == 8'h7B);
    is_rbrace  = (in_data == 8'h7D);
    is_lbrack  = (in_data == 8'h5B);
    is_rbrack  = (in_data == 8'h5D);
    is_quote   = (in_data == 8'h22);
    is_bslash  = (in_data == 8'h5C);
    is_colon   = (in_data == 8'h3A);
    is_comma   = (in_data == 8'h2C);
    is_open    = is_lbrace || is_lbrack;
    is_close   = is_rbrace || is_rbrack;
    is_struct  = is_open || is_close || is_colon || is_comma;
    is_scalar_start = (in_data == 8'h2D) ||
                      ((in_data >= 8'h30) && (in_data <= 8'h39)) ||
                      (in_data == 8'h74) || (in_data == 8'h66) || (in_data == 8'h6E);
    top_is_obj = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top_is_obj = stack_q[i];
    end
  end

  logic [2:0]           state_n;
  logic [DW-1:0]        depth_n;
  logic [MAX_DEPTH-1:0] stack_n;
  logic                 jo_n;
  logic                 emit, fault, do_after, do_close;
  logic [3:0]           kind_n;
  logic [2:0]           fault_kind;

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    stack_d       = stack_q;
    pos_d         = pos_q;
    just_opened_d = just_opened_q;
    tok_valid_d   = tok_valid_q && !tok_ready;
    tok_kind_d    = tok_kind_q;
    tok_pos_d     = tok_pos_q;
    tok_depth_d   = tok_depth_q;
    done_d        = done_q;
    err_d         = err_q;
    err_kind_d    = err_kind_q;
    err_pos_d     = err_pos_q;

    state_n    = state_q;
    depth_n    = depth_q;
    stack_n    = stack_q;
    jo_n       = just_opened_q;
    emit       = 1'b0;
    kind_n     = 4'd0;
    fault      = 1'b0;
    fault_kind = 3'd0;
    do_after   = 1'b0;
    do_close   = 1'b0;

    if (accept) begin
      pos_d = pos_q + POS_W'(1);

      case (state_q)
        S_EXPECT: begin
          if (is_open) begin
            if (depth_q == DW'(MAX_DEPTH)) begin
              fault      = 1'b1;
              fault_kind = E_OVERFLOW;
            end else begin
              for (int i = 0; i < MAX_DEPTH; i++) begin
                if (depth_q == DW'(i)) stack_n[i] = is_lbrace;
              end
              depth_n = depth_q + DW'(1);
              emit    = 1'b1;
              kind_n  = is_lbrace ? K_OBJ_START : K_ARR_START;
              jo_n    = 1'b1;
            end
          end else if (is_quote) begin
            emit    = 1'b1;
            kind_n  = K_STR_START;
            state_n = S_IN_STR;
            jo_n    = 1'b0;
          end else if (is_scalar_start) begin
            emit    = 1'b1;
            kind_n  = K_SCALAR;
            state_n = S_IN_SCALAR;
            jo_n    = 1'b0;
          end else if (is_close && just_opened_q) begin
            do_close = 1'b1;
          end else if (!is_ws) begin
            fault      = 1'b1;
            fault_kind = E_UNEXPECTED;
          end
        end
        S_IN_STR: begin
          if (is_bslash) begin
            state_n = S_IN_ESC;
          end else if (is_quote) begin
            emit    = 1'b1;
            kind_n  = K_STR_END;
            state_n = (depth_q == '0) ? S_TOP_DONE : S_AFTER;
          end
        end
        S_IN_ESC: state_n = S_IN_STR;
        S_IN_SCALAR: begin
          if (is_ws) begin
            state_n = (depth_q == '0) ? S_TOP_DONE : S_AFTER;
          end else if (is_quote) begin
            fault      = 1'b1;
            fault_kind = E_UNEXPECTED;
          end else if (is_struct) begin
            // scalar ends here; the terminator itself is handled as after a value
            do_after = 1'b1;
          end
        end
        S_AFTER: do_after = 1'b1;
        S_TOP_DONE: begin
          if (!is_ws) begin
            fault      = 1'b1;
            fault_kind = E_TRAILING;
          end
        end
        default: begin
          fault      = 1'b1;
          fault_kind = E_UNEXPECTED;
        end
      endcase

      if (do_after) begin
        if (is_ws) begin
          state_n = S_AFTER;
        end else if (is_comma && (depth_q != '0)) begin
          emit    = 1'b1;
          kind_n  = K_COMMA;
          state_n = S_EXPECT;
          jo_n    = 1'b0;
        end else if (is_colon && (depth_q != '0) && top_is_obj) begin
          emit    = 1'b1;
          kind_n  = K_COLON;
          state_n = S_EXPECT;
          jo_n    = 1'b0;
        end else if (is_close) begin
          do_close = 1'b1;
        end else begin
          fault      = 1'b1;
          fault_kind = E_UNEXPECTED;
        end
      end

      if (do_close) begin
        if ((depth_q == '0) || (top_is_obj != is_rbrace)) begin
          fault      = 1'b1;
          fault_kind = E_MISMATCH;
        end else begin
          depth_n = depth_q - DW'(1);
          emit    = 1'b1;
          kind_n  = is_rbrace ? K_OBJ_END : K_ARR_END;
          state_n = (depth_n == '0) ? S_TOP_DONE : S_AFTER;
          jo_n    = 1'b0;
        end
      end

      // end-of-document judgement uses the state after this byte
      if (in_last && !fault) begin
        if ((state_n == S_TOP_DONE) || ((state_n == S_IN_SCALAR) && (depth_n == '0))) begin
          done_d = 1'b1;
        end else begin
          fault      = 1'b1;
          fault_kind = ((state_n == S_IN_STR) || (state_n == S_IN_ESC)) ?
                       E_EOF_STRING : E_EOF_VALUE;
        end
      end

      if (fault) begin
        err_d      = 1'b1;
        err_kind_d = fault_kind;
        err_pos_d  = pos_q;
      end else begin
        state_d       = state_n;
        depth_d       = depth_n;
        stack_d       = stack_n;
        just_opened_d = jo_n;
        if (emit) begin
          tok_valid_d = 1'b1;
          tok_kind_d  = kind_n;
          tok_pos_d   = pos_q;
          tok_depth_d = depth_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_EXPECT;
      depth_q       <= '0;
      stack_q       <= '0;
      pos_q         <= '0;
      just_opened_q <= 1'b0;
      tok_valid_q   <= 1'b0;
      tok_kind_q    <= '0;
      tok_pos_q     <= '0;
      tok_depth_q   <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_kind_q    <= '0;
      err_pos_q     <= '0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      stack_q       <= stack_d;
      pos_q         <= pos_d;
      just_opened_q <= just_opened_d;
      tok_valid_q   <= tok_valid_d;
      tok_kind_q    <= tok_kind_d;
      tok_pos_q     <= tok_pos_d;
      tok_depth_q   <= tok_depth_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_kind_q    <= err_kind_d;
      err_pos_q     <= err_pos_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_kind  = tok_kind_q;
  assign tok_pos   = tok_pos_q;
  assign tok_depth = tok_depth_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_kind  = err_kind_q;
  assign err_pos   = err_pos_q;

endmodule

// File: tb/tb_json_scan_ctrl.sv
module tb_json_scan_ctrl;
  localparam int MAX_DEPTH = 4;
  localparam int POS_W     = 32;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  localparam logic [3:0] K_OBJ_START = 4'd1;
  localparam logic [3:0] K_OBJ_END   = 4'd2;
  localparam logic [3:0] K_ARR_START = 4'd3;
  localparam logic [3:0] K_ARR_END   = 4'd4;
  localparam logic [3:0] K_STR_START = 4'd5;
  localparam logic [3:0] K_STR_END   = 4'd6;
  localparam logic [3:0] K_SCALAR    = 4'd7;
  localparam logic [3:0] K_COLON     = 4'd8;
  localparam logic [3:0] K_COMMA     = 4'd9;
  localparam logic [3:0] K_NONE      = 4'd0;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_data;
  logic             tok_valid, tok_ready;
  logic [3:0]       tok_kind;
  logic [POS_W-1:0] tok_pos;
  logic [DW-1:0]    tok_depth;
  logic             done, err;
  logic [2:0]       err_kind;
  logic [POS_W-1:0] err_pos;

  typedef struct packed {
    logic [3:0]       kind;
    logic [POS_W-1:0] pos;
    logic [DW-1:0]    depth;
  } tok_t;

  tok_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos_model = 0;
  int   stall_cycles = 0;

  always #5 clk = ~clk;

  json_scan_ctrl #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_pos(tok_pos), .tok_depth(tok_depth),
    .done(done), .err(err), .err_kind(err_kind), .err_pos(err_pos)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    tok_t got;
    tok_t want;
    if (tok_valid && tok_ready) begin
      got.kind  = tok_kind;
      got.pos   = tok_pos;
      got.depth = tok_depth;
      chk("token_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("token_kind_pos_depth", 64'(got), 64'(want));
      end
    end
  endtask

  task automatic step(output logic acc);
    @(negedge clk);
    monitor();
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input logic [3:0] kind, input int depth);
    logic acc;
    int   n;
    tok_t t;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    if (kind != K_NONE) begin
      t.kind  = kind;
      t.pos   = POS_W'(pos_model);
      t.depth = DW'(depth);
      exp_q.push_back(t);
    end
    pos_model++;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    stall_cycles += n - 1;
    chk("byte_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(acc);
      n++;
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) step(acc);
  endtask

  task automatic do_reset();
    logic acc;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.delete();
    pos_model = 0;
    step(acc);
    step(acc);
    rst = 1'b0;
  endtask

  task automatic chk_err(input string tag, input logic [2:0] kind, input int pos);
    chk({tag, "_err"}, 64'(err), 64'd1);
    chk({tag, "_err_kind"}, 64'(err_kind), 64'(kind));
    chk({tag, "_err_pos"}, 64'(err_pos), 64'(pos));
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    logic acc;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; tok_ready = 1'b0;
    do_reset();
    chk("rst_tok_valid", 64'(tok_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_kind", 64'(err_kind), 64'd0);
    chk("rst_err_pos", 64'(err_pos), 64'd0);
    chk("rst_tok_kind", 64'(tok_kind), 64'd0);
    chk("rst_tok_pos", 64'(tok_pos), 64'd0);
    chk("rst_tok_depth", 64'(tok_depth), 64'd0);

    // {"a":[1,true]}
    tok_ready = 1'b1;
    stall_cycles = 0;
    send("{", 0, K_OBJ_START, 1);
    send(8'h22, 0, K_STR_START, 1);
    send("a", 0, K_NONE, 0);
    send(8'h22, 0, K_STR_END, 1);
    send(":", 0, K_COLON, 1);
    send("[", 0, K_ARR_START, 2);
    send("1", 0, K_SCALAR, 2);
    send(",", 0, K_COMMA, 2);
    send("t", 0, K_SCALAR, 2);
    send("r", 0, K_NONE, 0);
    send("u", 0, K_NONE, 0);
    send("e", 0, K_NONE, 0);
    send("]", 0, K_ARR_END, 1);
    send("}", 1, K_OBJ_END, 0);
    chk("doc1_stalls", 64'(stall_cycles), 64'd0);
    drain();
    chk("doc1_done", 64'(done), 64'd1);
    chk("doc1_err", 64'(err), 64'd0);
    chk("doc1_in_ready", 64'(in_ready), 64'd0);

    // "a\"}"
    do_reset();
    send(8'h22, 0, K_STR_START, 0);
    send("a", 0, K_NONE, 0);
    send(8'h5C, 0, K_NONE, 0);
    send(8'h22, 0, K_NONE, 0);
    send("}", 0, K_NONE, 0);
    send(8'h22, 1, K_STR_END, 0);
    drain();
    chk("doc2_done", 64'(done), 64'd1);
    chk("doc2_err", 64'(err), 64'd0);

    // [1}
    do_reset();
    send("[", 0, K_ARR_START, 1);
    send("1", 0, K_SCALAR, 1);
    send("}", 0, K_NONE, 0);
    drain();
    chk_err("mismatch", 3'd3, 2);

    // [[[[[ with depth limit 4
    do_reset();
    for (int i = 1; i <= 4; i++) send("[", 0, K_ARR_START, i);
    send("[", 0, K_NONE, 0);
    drain();
    chk_err("overflow", 3'd4, 4);

    // 12 x
    do_reset();
    send("1", 0, K_SCALAR, 0);
    send("2", 0, K_NONE, 0);
    send(" ", 0, K_NONE, 0);
    send("x", 1, K_NONE, 0);
    drain();
    chk_err("trailing", 3'd5, 3);

    // {"k
    do_reset();
    send("{", 0, K_OBJ_START, 1);
    send(8'h22, 0, K_STR_START, 1);
    send("k", 1, K_NONE, 0);
    drain();
    chk_err("eof_string", 3'd2, 2);

    // "[ " ending in whitespace inside an array
    do_reset();
    send("[", 0, K_ARR_START, 1);
    send(" ", 1, K_NONE, 0);
    drain();
    chk_err("eof_value", 3'd1, 1);

    // x as first byte
    do_reset();
    send("x", 0, K_NONE, 0);
    drain();
    chk_err("unexpected", 3'd6, 0);

    // backpressure then mid-stream reset
    do_reset();
    tok_ready = 1'b0;
    send("{", 0, K_OBJ_START, 1);
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      chk("bp_no_accept", 64'(acc), 64'd0);
      chk("bp_tok_valid", 64'(tok_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_tok_kind", 64'(tok_kind), 64'(K_OBJ_START));
      chk("bp_tok_pos", 64'(tok_pos), 64'd0);
      chk("bp_tok_depth", 64'(tok_depth), 64'd1);
    end
    tok_ready = 1'b1;
    send(8'h22, 0, K_STR_START, 1);
    send("a", 0, K_NONE, 0);
    tok_ready = 1'b0;
    send(8'h22, 0, K_STR_END, 1);
    chk("pre_rst_tok_valid", 64'(tok_valid), 64'd1);
    do_reset();
    chk("mid_rst_tok_valid", 64'(tok_valid), 64'd0);
    chk("mid_rst_tok_depth", 64'(tok_depth), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tok_ready = 1'b1;
    send("[", 0, K_ARR_START, 1);
    send("]", 1, K_ARR_END, 0);
    drain();
    chk("post_rst_done", 64'(done), 64'd1);
    chk("post_rst_err", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/json_scan_ctrl.md
Name: json_scan_ctrl

Overview:
- Streaming structural scanner and sequencer for the JSON decoding datapath.
- Consumes a byte stream, tracks lexical state (string, escape, scalar) and a bracket nesting stack.
- Emits one structural token per significant byte to the downstream value builder.
- Detects and reports syntax errors with an error kind and byte position, using the same error taxonomy as the software decoder.

Parameters:
- MAX_DEPTH, 16: maximum nesting depth of objects/arrays; legal range 1..64.
- POS_W, 32: width of the byte position counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- in_last  in  1  marks the final byte of the document.
- tok_valid  out  1  token valid.
- tok_ready  in  1  downstream accepts token.
- tok_kind  out  4  token kind: 1 OBJ_START, 2 OBJ_END, 3 ARR_START, 4 ARR_END, 5 STR_START, 6 STR_END, 7 SCALAR_START, 8 COLON, 9 COMMA.
- tok_pos  out  POS_W  byte index of the token character.
- tok_depth  out  $clog2(MAX_DEPTH+1)  nesting depth after the token is applied.
- done  out  1  sticky; the document completed without error.
- err  out  1  sticky; a syntax error was detected.
- err_kind  out  3  error kind: 1 EOF_VALUE, 2 EOF_STRING, 3 BRACKET_MISMATCH, 4 DEPTH_OVERFLOW, 5 TRAILING_CHARS, 6 UNEXPECTED_CHAR.
- err_pos  out  POS_W  byte index of the offending byte.

Behaviour:
- Reset: all outputs 0; state EXPECT_VALUE; depth 0; position counter 0; stack cleared.
- in_ready = !done && !err && (!tok_valid || tok_ready).
- Each accepted byte advances the position counter by 1, starting at 0.
- Token latency: a byte accepted in cycle N drives tok_valid in cycle N+1.
  - The token is held stable until tok_ready is sampled high.
  - Each byte produces at most one token.
- Full throughput: one byte per cycle when tok_ready is held high.
- Whitespace (0x20, 0x09, 0x0A, 0x0D) outside strings: no token. It terminates a scalar.
- States:
  - EXPECT_VALUE:
    - '{' or '[': push 1 (object) or 0 (array), depth+1, emit start token, set just_opened.
    - '"': STR_START, go to IN_STR.
    - One of -0123456789tfn: SCALAR_START, go to IN_SCALAR.
    - '}' or ']' with just_opened set: close the empty container.
    - Anything else: UNEXPECTED_CHAR.
  - IN_STR:
    - '\': go to IN_ESC, no token.
    - '"': STR_END, go to AFTER_VALUE.
    - Other bytes: no token.
  - IN_ESC: any byte returns to IN_STR, no token.
  - IN_SCALAR: bytes other than whitespace, structural characters or '"' produce no token. A terminator ends the scalar and is then processed as in AFTER_VALUE in the same cycle. '"' is UNEXPECTED_CHAR.
  - AFTER_VALUE:
    - ',' at depth>=1: COMMA, go to EXPECT_VALUE.
    - ':' with object on top of stack: COLON, go to EXPECT_VALUE.
    - '}' or ']': must match top of stack, else BRACKET_MISMATCH. On match, pop, depth-1, emit end token.
    - Any other non-whitespace: UNEXPECTED_CHAR.
  - TOP_DONE: entered when a value completes at depth 0. Any non-whitespace byte is TRAILING_CHARS.
- Depth checks:
  - Open at depth==MAX_DEPTH: DEPTH_OVERFLOW, no push.
  - Close at depth 0: BRACKET_MISMATCH.
- in_last on an accepted byte, after processing that byte:
  - Complete document (TOP_DONE, or a scalar at depth 0): done=1 in the next cycle.
  - Ending in IN_STR or IN_ESC: EOF_STRING.
  - Any other state: EOF_VALUE.
  - err_pos for these EOF errors = position of the last byte.
- Errors:
  - err, err_kind and err_pos are registered in the cycle after the offending byte is accepted. No token is emitted for that byte.
  - Any pending token still completes its handshake.
  - The first error wins; later bytes are not accepted.
- rst asserted mid-document aborts immediately. A pending token is dropped and all state returns to reset values.
- Simultaneous token stall and error: err is not blocked by tok_ready.

Test Plan:
- Input {"a":[1,true]} with tok_ready=1 gives tokens in order:
  - OBJ_START @0 d1
  - STR_START @1 d1
  - STR_END @3 d1
  - COLON @4 d1
  - ARR_START @5 d2
  - SCALAR_START @6 d2
  - COMMA @7 d2
  - SCALAR_START @8 d2
  - ARR_END @12 d1
  - OBJ_END @13 d0
  - Then done=1, err=0.
- Input "a\"}" with last on the final '"' gives STR_START @0 and STR_END @5; the escaped quote and '}' produce no tokens; done=1.
- Input [1} gives err_kind=3 with err_pos=2; no OBJ_END token; in_ready=0 afterwards.
- With MAX_DEPTH=4, input [[[[[ gives four ARR_START tokens, then err_kind=4 with err_pos=4.
- Input 12 x with last on 'x' gives err_kind=5 with err_pos=3. Input {"k with last on 'k' gives err_kind=2 with err_pos=2.
- Backpressure: tok_ready=0 for 5 cycles after '{' holds tok_valid=1, in_ready=0 and the token stable. rst pulsed mid-stream clears tok_valid, depth and position to 0.
